// File: rtl/frame_buf_arbiter.sv
`default_nettype none
// =============================================================================
// Module : frame_buf_arbiter
// Shares one single-port frame RAM between LCD scan-out reads and a
// double-buffered pixel writer; bank swaps are deferred to vertical blanking.
// Rev    : 1.0
// =============================================================================
module frame_buf_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 130560,
    parameter int CNT_W       = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    // LCD scan-out read path
    input  logic              iLcdEn,
    input  logic [ADDR_W-1:0] iLcdRdAddr,
    input  logic              iLcdVSync,
    output logic [DATA_W-1:0] oLcdRdData,
    // Writer path
    input  logic              iWrValid,
    output logic              oWrReady,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iWrFrameDone,
    // Status
    output logic              oSwapDone,
    output logic              oDispBank,
    output logic [CNT_W-1:0]  oFrameCnt,
    output logic              oOverrun,
    output logic              oAddrErr,
    // RAM port
    output logic              oRamEn,
    output logic              oRamWe,
    output logic [ADDR_W:0]   oRamAddr,
    output logic [DATA_W-1:0] oRamWrData,
    input  logic [DATA_W-1:0] iRamRdData
);

    localparam logic [ADDR_W:0] c_FRAME_LIMIT = (ADDR_W+1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_VBLANK = 2'd1,
        S_SWAP        = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_swap_done;

    logic                r_disp_bank;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                r_overrun;
    logic                r_addr_err;
    logic                r_vsync_d;
    logic                r_rd_pend;
    logic [DATA_W-1:0]   r_lcd_rd_data;

    logic                w_vblank_start;
    logic                w_wr_ready;
    logic                w_wr_accept;
    logic                w_addr_in_range;
    logic                w_wr_commit;

    assign w_vblank_start  = ~iLcdVSync & r_vsync_d;
    assign w_wr_ready      = ~iLcdEn & (r_state == S_IDLE);
    assign w_wr_accept     = iWrValid & w_wr_ready;
    assign w_addr_in_range = ({1'b0, iWrAddr} < c_FRAME_LIMIT);
    // Out-of-range pixels still handshake so the writer never stalls on them.
    assign w_wr_commit     = w_wr_accept & w_addr_in_range;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A frame-done arriving on the same cycle as the blanking edge only arms the
    // swap; the edge that triggers it must come strictly later.
    always_comb begin
        w_state_nxt = r_state;
        w_swap_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iWrFrameDone) begin
                    w_state_nxt = S_WAIT_VBLANK;
                end
            end
            S_WAIT_VBLANK: begin
                if (w_vblank_start) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                w_swap_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_disp_bank   <= 1'b0;
            r_frame_cnt   <= '0;
            r_overrun     <= 1'b0;
            r_addr_err    <= 1'b0;
            r_vsync_d     <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_lcd_rd_data <= '0;
        end else begin
            r_vsync_d <= iLcdVSync;
            r_rd_pend <= iLcdEn;
            if (r_rd_pend) begin
                r_lcd_rd_data <= iRamRdData;
            end
            // Bank flips at the end of the swap cycle so a read in that cycle
            // still sees the old display bank.
            if (r_state == S_SWAP) begin
                r_disp_bank <= ~r_disp_bank;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (iWrFrameDone && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_wr_accept && !w_addr_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        oRamEn     = 1'b0;
        oRamWe     = 1'b0;
        oRamAddr   = '0;
        oRamWrData = '0;
        if (iLcdEn) begin
            oRamEn   = 1'b1;
            oRamAddr = {r_disp_bank, iLcdRdAddr};
        end else if (w_wr_commit) begin
            oRamEn     = 1'b1;
            oRamWe     = 1'b1;
            oRamAddr   = {~r_disp_bank, iWrAddr};
            oRamWrData = iWrData;
        end
    end

    assign oWrReady   = w_wr_ready;
    assign oSwapDone  = w_swap_done;
    assign oDispBank  = r_disp_bank;
    assign oFrameCnt  = r_frame_cnt;
    assign oOverrun   = r_overrun;
    assign oAddrErr   = r_addr_err;
    assign oLcdRdData = r_lcd_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : tb_frame_buf_arbiter
// Self-checking bench: vector table, directed swap sequences, random traffic.
// Rev    : 1.0
// =============================================================================
module tb_frame_buf_arbiter;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 16;
    localparam int FRAME_WORDS = 130560;
    localparam int CNT_W       = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lcd_en = 1'b0;
    logic [ADDR_W-1:0] lcd_addr = '0;
    logic              vsync = 1'b0;
    logic [DATA_W-1:0] lcd_data;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              frame_done = 1'b0;
    logic              swap_done;
    logic              disp_bank;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overrun;
    logic              addr_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always #5 clk = ~clk;

    frame_buf_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS), .CNT_W(CNT_W)
    ) dut (
        .iClk(clk), .iRst(rst),
        .iLcdEn(lcd_en), .iLcdRdAddr(lcd_addr), .iLcdVSync(vsync), .oLcdRdData(lcd_data),
        .iWrValid(wr_valid), .oWrReady(wr_ready), .iWrAddr(wr_addr), .iWrData(wr_data),
        .iWrFrameDone(frame_done),
        .oSwapDone(swap_done), .oDispBank(disp_bank), .oFrameCnt(frame_cnt),
        .oOverrun(overrun), .oAddrErr(addr_err),
        .oRamEn(ram_en), .oRamWe(ram_we), .oRamAddr(ram_addr), .oRamWrData(ram_wdata),
        .iRamRdData(ram_rdata)
    );

    // Preloaded contents: bank0 word = address, bank1 word = address ^ A5A5.
    function automatic logic [15:0] preload(input int a);
        logic [17:0] av;
        av = 18'(a);
        return av[17] ? (av[15:0] ^ 16'hA5A5) : av[15:0];
    endfunction

    // Single-port synchronous RAM; read data is junk on cycles with no read.
    logic [15:0] ram [int];
    logic [15:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram[int'(ram_addr)] = ram_wdata;
        end
        if (ram_en && !ram_we) begin
            ram_q <= ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : preload(int'(ram_addr));
        end else begin
            ram_q <= 16'($urandom);
        end
    end
    assign ram_rdata = ram_q;

    // ---------------- reference model ----------------
    typedef struct { int unsigned due; logic [15:0] v; } rd_t;
    logic [15:0]  m_mem [int];
    rd_t          m_q[$];
    rd_t          m_item;
    bit           m_pend, m_swap, m_bank, m_vs_prev, m_ovr, m_aerr;
    bit           m_acc, m_we, m_inrange, m_vb;
    int unsigned  m_cnt, m_cyc;
    logic [15:0]  m_lcd;
    int           m_idx;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0; m_swap = 0; m_bank = 0; m_vs_prev = 0; m_ovr = 0; m_aerr = 0;
            m_cnt = 0; m_lcd = '0;
            m_q.delete();
        end else begin
            m_inrange = int'(wr_addr) < FRAME_WORDS;
            m_acc     = wr_valid && !lcd_en && !m_pend && !m_swap;
            m_we      = m_acc && m_inrange;
            if (m_acc && !m_inrange) m_aerr = 1;
            if (m_we) m_mem[int'({~m_bank, wr_addr})] = wr_data;
            if (lcd_en) begin
                m_idx       = int'({m_bank, lcd_addr});
                m_item.due  = m_cyc + 2;
                m_item.v    = m_mem.exists(m_idx) ? m_mem[m_idx] : preload(m_idx);
                m_q.push_back(m_item);
            end
            if (frame_done && (m_pend || m_swap)) m_ovr = 1;
            m_vb = !vsync && m_vs_prev;
            if (m_swap) begin
                m_bank = !m_bank; m_cnt++; m_swap = 0;
            end else if (m_pend) begin
                if (m_vb) begin m_swap = 1; m_pend = 0; end
            end else if (frame_done) begin
                m_pend = 1;
            end
            m_vs_prev = vsync;
        end
        m_cyc++;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            m_lcd = m_q[0].v;
            void'(m_q.pop_front());
        end
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit le, input logic [16:0] ra, input bit vs, input bit wv,
                       input logic [16:0] wa, input logic [15:0] wd, input bit fd);
        lcd_en = le; lcd_addr = ra; vsync = vs; wr_valid = wv;
        wr_addr = wa; wr_data = wd; frame_done = fd;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    task automatic check_model();
        bit          rdy, we, en;
        logic [17:0] addr;
        rdy  = !lcd_en && !m_pend && !m_swap;
        we   = rdy && wr_valid && (int'(wr_addr) < FRAME_WORDS);
        en   = lcd_en || we;
        addr = lcd_en ? {m_bank, lcd_addr} : {~m_bank, wr_addr};
        check("rnd_ready", 32'(wr_ready), 32'(rdy));
        check("rnd_ram_en", 32'(ram_en), 32'(en));
        check("rnd_ram_we", 32'(ram_we), 32'(we));
        if (en) check("rnd_ram_addr", 32'(ram_addr), 32'(addr));
        if (we) check("rnd_ram_wdata", 32'(ram_wdata), 32'(wr_data));
        check("rnd_swap_done", 32'(swap_done), 32'(m_swap));
        check("rnd_disp_bank", 32'(disp_bank), 32'(m_bank));
        check("rnd_frame_cnt", 32'(frame_cnt), m_cnt % 256);
        check("rnd_overrun", 32'(overrun), 32'(m_ovr));
        check("rnd_addr_err", 32'(addr_err), 32'(m_aerr));
        check("rnd_lcd_data", 32'(lcd_data), 32'(m_lcd));
    endtask

    task automatic do_swap(input string name);
        bit seen;
        seen = 0;
        drv(0, 0, 1, 0, 0, 0, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (swap_done) seen = 1;
            nxt();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        bit          lcd;
        logic [16:0] ra;
        bit          wv;
        logic [16:0] wa;
        logic [15:0] wd;
        bit          rdy;
        bit          en;
        bit          we;
        logic [17:0] addr;
        logic [15:0] lcd_data;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int gap;
        bit v_le, v_vs, v_wv, v_fd;
        logic [16:0] v_wa;

        // Idle display bank is 0 throughout the table.
        tbl[0] = '{1, 17'd5,       1, 17'd7,      16'hAAAA, 0, 1, 0, 18'h00005, 16'h0000};
        tbl[1] = '{0, 17'd0,       1, 17'd7,      16'hAAAA, 1, 1, 1, 18'h20007, 16'h0000};
        tbl[2] = '{0, 17'd0,       0, 17'd0,      16'h0000, 1, 0, 0, 18'h00000, 16'h0005};
        tbl[3] = '{1, 17'h1FFFF,   0, 17'd0,      16'h0000, 0, 1, 0, 18'h1FFFF, 16'h0005};
        tbl[4] = '{0, 17'd0,       1, 17'd130559, 16'h0001, 1, 1, 1, 18'h3FDFF, 16'h0005};
        tbl[5] = '{0, 17'd0,       1, 17'd130560, 16'h0002, 1, 0, 0, 18'h00000, 16'hFFFF};

        do_reset();
        @(negedge clk);
        check("rst_disp_bank", 32'(disp_bank), 0);
        check("rst_lcd_data", 32'(lcd_data), 0);
        check("rst_swap_done", 32'(swap_done), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_ready", 32'(wr_ready), 1);
        check("rst_ram_en", 32'(ram_en), 0);
        nxt();

        for (int i = 0; i < 6; i++) begin
            drv(tbl[i].lcd, tbl[i].ra, 0, tbl[i].wv, tbl[i].wa, tbl[i].wd, 0);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].en));
            check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].we));
            if (tbl[i].en) check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
            if (tbl[i].we) check($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].wd));
            check($sformatf("vec%0d_lcd_data", i), 32'(lcd_data), 32'(tbl[i].lcd_data));
            nxt();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("range_addr_err", 32'(addr_err), 1);
        nxt();

        // Write + frame done in one cycle, swap at blanking, reads across the swap.
        do_reset();
        drv(0, 0, 1, 1, 17'd5, 16'h1234, 1);
        @(negedge clk);
        check("s3_wr_ready", 32'(wr_ready), 1);
        check("s3_wr_addr", 32'(ram_addr), 32'h20005);
        check("s3_wr_we", 32'(ram_we), 1);
        nxt();
        drv(0, 0, 0, 1, 17'd6, 16'h5555, 0);
        @(negedge clk);
        check("s3_wait_ready", 32'(wr_ready), 0);
        check("s3_wait_ram_en", 32'(ram_en), 0);
        check("s3_wait_swap", 32'(swap_done), 0);
        nxt();
        drv(1, 17'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s3_swap_pulse", 32'(swap_done), 1);
        check("s3_swap_bank_old", 32'(disp_bank), 0);
        check("s3_swap_rd_addr", 32'(ram_addr), 32'h00005);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s3_post_swap", 32'(swap_done), 0);
        check("s3_post_bank", 32'(disp_bank), 1);
        check("s3_post_cnt", 32'(frame_cnt), 1);
        check("s3_no_overrun", 32'(overrun), 0);
        nxt();
        drv(1, 17'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s3_new_rd_addr", 32'(ram_addr), 32'h20005);
        check("s3_old_bank_data", 32'(lcd_data), 32'h0005);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        nxt();
        @(negedge clk);
        check("s3_new_bank_data", 32'(lcd_data), 32'h1234);
        nxt();

        // Overrun, single swap, and frame done coincident with blanking edge.
        do_reset();
        drv(0, 0, 1, 0, 0, 0, 1); nxt();
        drv(0, 0, 1, 0, 0, 0, 1); nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s4_overrun", 32'(overrun), 1);
        check("s4_no_swap_yet", 32'(swap_done), 0);
        nxt();
        @(negedge clk);
        check("s4_swap", 32'(swap_done), 1);
        nxt();
        @(negedge clk);
        check("s4_cnt", 32'(frame_cnt), 1);
        check("s4_overrun_sticky", 32'(overrun), 1);
        nxt();
        drv(0, 0, 1, 0, 0, 0, 0); nxt();
        drv(0, 0, 0, 0, 0, 0, 0); nxt();
        @(negedge clk);
        check("s4_single_swap", 32'(swap_done), 0);
        check("s4_cnt_still", 32'(frame_cnt), 1);
        drv(0, 0, 1, 0, 0, 0, 0); nxt();
        drv(0, 0, 0, 0, 0, 0, 1); nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s4_edge_unused", 32'(swap_done), 0);
        nxt();
        drv(0, 0, 1, 0, 0, 0, 0); nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("s4_wait_next_edge", 32'(swap_done), 0);
        nxt();
        @(negedge clk);
        check("s4_late_swap", 32'(swap_done), 1);
        nxt();
        @(negedge clk);
        check("s4_cnt2", 32'(frame_cnt), 2);
        nxt();

        // Counter wrap, then reset while a swap is pending.
        do_reset();
        for (int n = 0; n < 256; n++) do_swap("wrap_swap");
        @(negedge clk);
        check("wrap_cnt", 32'(frame_cnt), 0);
        check("wrap_bank", 32'(disp_bank), 0);
        nxt();
        do_swap("pre_rst_swap");
        @(negedge clk);
        check("pre_rst_bank", 32'(disp_bank), 1);
        nxt();
        drv(0, 0, 1, 0, 0, 0, 1); nxt();
        drv(0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1; nxt();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_bank", 32'(disp_bank), 0);
        check("rst_wait_cnt", 32'(frame_cnt), 0);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (swap_done) seen = 1;
            nxt();
        end
        check("rst_wait_no_swap", 32'(seen), 0);
        @(negedge clk);
        check("rst_wait_bank_hold", 32'(disp_bank), 0);
        nxt();

        // Random traffic against the reference model.
        do_reset();
        gap = 2;
        v_vs = 0;
        for (int c = 0; c < 3000; c++) begin
            v_le = (gap >= 2) && ($urandom_range(0, 1) == 1);
            gap  = v_le ? 1 : gap + 1;
            if ($urandom_range(0, 7) == 0) v_vs = !v_vs;
            v_wv = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 31))
                0:       v_wa = 17'(130560 + $urandom_range(0, 7));
                1:       v_wa = 17'd130559;
                default: v_wa = 17'($urandom_range(0, 63));
            endcase
            v_fd = $urandom_range(0, 39) == 0;
            drv(v_le, 17'($urandom_range(0, 63)), v_vs, v_wv, v_wa, 16'($urandom), v_fd);
            @(negedge clk);
            check_model();
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
